// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/accumulator.
//   op_e            : request opcode (ADD, SUB, ACC, CLR)
//   is_acc_clr      : true for the opcodes that touch the accumulator
//   lookahead_carry : carry into position n of a propagate/generate chain,
//                     written as a flat sum of products (no ripple)
package cla_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    function automatic logic is_acc_clr(input op_e o);
        return (o == OP_ACC) || (o == OP_CLR);
    endfunction

    // c[n] = c0&p[0..n-1] | OR_j ( g[j] & p[j+1..n-1] )
    function automatic logic lookahead_carry(input int n,
                                             input logic [31:0] p,
                                             input logic [31:0] g,
                                             input logic c0);
        logic cy;
        logic t;
        t = c0;
        for (int k = 0; k < n; k++) t = t & p[k];
        cy = t;
        for (int j = 0; j < n; j++) begin
            t = g[j];
            for (int k = j + 1; k < n; k++) t = t & p[k];
            cy = cy | t;
        end
        return cy;
    endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead slice.
//   x, y : operand bits of this group
//   cin  : carry into the group
//   sum  : group sum bits
//   gp   : group propagate (carry passes straight through)
//   gg   : group generate (carry produced regardless of cin)
// gp/gg do not depend on cin, so the enclosing lookahead can feed cin back
// without forming a combinational loop.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] x,
    input  logic [GROUP-1:0] y,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             gp,
    output logic             gg
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] c;

    assign p  = x ^ y;
    assign g  = x & y;
    assign gp = &p;
    assign gg = lookahead_carry(GROUP, 32'(p), 32'(g), 1'b0);

    always_comb begin
        c = '0;
        for (int i = 0; i < GROUP; i++) begin
            c[i] = lookahead_carry(i, 32'(p), 32'(g), cin);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/cla_pipe_acc.sv
// Two-stage pipelined carry-lookahead adder / subtractor / accumulator.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : request handshake
//   op, a, b, cin       : opcode (cla_pkg::op_e), operands, carry-in
//   out_valid, out_ready: result handshake
//   sum, cout, ovf      : result, carry out of MSB, signed overflow
//   acc_ovf             : sticky signed overflow of accumulate operations
// Stage 1 computes the lower half and the carry into the upper half and
// registers it; stage 2 finishes the upper half into the output register.
// ACC/CLR hold off the next request while in stage 1 so the following
// ACC reads the accumulator after it has been written.
// WIDTH/2 must be a multiple of GROUP.
module cla_pipe_acc
    import cla_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             acc_ovf
);

    localparam int HALF = WIDTH / 2;
    localparam int NG   = HALF / GROUP;

    op_e              op_in;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             c_in;
    logic [WIDTH-1:0] acc;

    logic [HALF-1:0]  lo_sum;
    logic [NG-1:0]    gp_lo;
    logic [NG-1:0]    gg_lo;
    logic [NG-1:0]    c_lo;
    logic             c_mid;

    logic             vld_p1;
    op_e              op_p1;
    logic [HALF-1:0]  lo_sum_p1;
    logic             c_mid_p1;
    logic [HALF-1:0]  x_hi_p1;
    logic [HALF-1:0]  y_hi_p1;

    logic [HALF-1:0]  hi_sum;
    logic [NG-1:0]    gp_hi;
    logic [NG-1:0]    gg_hi;
    logic [NG-1:0]    c_hi;
    logic             cout_p2;
    logic             c_msb;
    logic             ovf_p2;
    logic [WIDTH-1:0] sum_p2;

    logic             accept;
    logic             adv;

    assign op_in = op_e'(op);

    // Every opcode reduces to x + y + c; CLR adds zeros so its result,
    // cout and ovf all come out as 0 with no special casing.
    always_comb begin
        x_in = '0;
        y_in = '0;
        c_in = 1'b0;
        case (op_in)
            OP_ADD: begin x_in = a;   y_in = b;  c_in = cin;  end
            OP_SUB: begin x_in = a;   y_in = ~b; c_in = 1'b1; end
            OP_ACC: begin x_in = acc; y_in = a;  c_in = cin;  end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_lo
        cla_group #(.GROUP(GROUP)) u_grp (
            .x   (x_in[gi*GROUP +: GROUP]),
            .y   (y_in[gi*GROUP +: GROUP]),
            .cin (c_lo[gi]),
            .sum (lo_sum[gi*GROUP +: GROUP]),
            .gp  (gp_lo[gi]),
            .gg  (gg_lo[gi])
        );
    end

    always_comb begin
        c_lo = '0;
        for (int i = 0; i < NG; i++) begin
            c_lo[i] = lookahead_carry(i, 32'(gp_lo), 32'(gg_lo), c_in);
        end
    end

    assign c_mid = lookahead_carry(NG, 32'(gp_lo), 32'(gg_lo), c_in);

    // Handshake: stage 1 moves into the output register whenever that
    // register is empty or being drained this cycle.
    assign adv      = vld_p1 && (!out_valid || out_ready);
    assign in_ready = !rst && (!vld_p1 || adv) && !(vld_p1 && is_acc_clr(op_p1));
    assign accept   = in_valid && in_ready;

    // ---- stage 1 register boundary ----
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p1     <= op_in;
            lo_sum_p1 <= lo_sum;
            c_mid_p1  <= c_mid;
            x_hi_p1   <= x_in[WIDTH-1:HALF];
            y_hi_p1   <= y_in[WIDTH-1:HALF];
        end
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_hi
        cla_group #(.GROUP(GROUP)) u_grp (
            .x   (x_hi_p1[gi*GROUP +: GROUP]),
            .y   (y_hi_p1[gi*GROUP +: GROUP]),
            .cin (c_hi[gi]),
            .sum (hi_sum[gi*GROUP +: GROUP]),
            .gp  (gp_hi[gi]),
            .gg  (gg_hi[gi])
        );
    end

    always_comb begin
        c_hi = '0;
        for (int i = 0; i < NG; i++) begin
            c_hi[i] = lookahead_carry(i, 32'(gp_hi), 32'(gg_hi), c_mid_p1);
        end
    end

    assign cout_p2 = lookahead_carry(NG, 32'(gp_hi), 32'(gg_hi), c_mid_p1);
    // Carry into the MSB recovered from its sum bit: s = x ^ y ^ c.
    assign c_msb   = hi_sum[HALF-1] ^ x_hi_p1[HALF-1] ^ y_hi_p1[HALF-1];
    assign ovf_p2  = c_msb ^ cout_p2;
    assign sum_p2  = {hi_sum, lo_sum_p1};

    // ---- stage 2 / output register boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            acc_ovf   <= 1'b0;
        end else begin
            if (accept) begin
                vld_p1 <= 1'b1;
            end else if (adv) begin
                vld_p1 <= 1'b0;
            end
            if (adv) begin
                out_valid <= 1'b1;
                if (op_p1 == OP_ACC && ovf_p2) begin
                    acc_ovf <= 1'b1;
                end else if (op_p1 == OP_CLR) begin
                    acc_ovf <= 1'b0;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            acc  <= '0;
        end else if (adv) begin
            sum  <= sum_p2;
            cout <= cout_p2;
            ovf  <= ovf_p2;
            if (op_p1 == OP_ACC) begin
                acc <= sum_p2;
            end else if (op_p1 == OP_CLR) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_acc.sv
// Bench for cla_pipe_acc (WIDTH=8, GROUP=4): directed vectors, a
// request-order model with a queue of expected results, and literal checks.
module tb_cla_pipe_acc;
    import cla_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       acc_ovf;

    always #5 clk = ~clk;

    cla_pipe_acc #(.WIDTH(8), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .acc_ovf   (acc_ovf)
    );

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ov;
        logic       ao;
    } exp_t;

    exp_t       expq[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] macc   = 8'h00;
    logic       maovf  = 1'b0;

    logic [7:0] lsum [0:255];
    logic       lco  [0:255];
    logic       lov  [0:255];
    logic       lao  [0:255];
    int         nlog = 0;

    logic [1:0] t_op [12] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0};
    logic [7:0] t_a  [12] = '{8'hFF, 8'h80, 8'h00, 8'h40, 8'h40, 8'h12, 8'h00, 8'hC0, 8'h7F, 8'h7F, 8'h00, 8'h55};
    logic [7:0] t_b  [12] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h34, 8'h01, 8'h00, 8'h7F, 8'h80, 8'h00, 8'hAA};
    logic       t_c  [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input logic c);
        int n;
        n = 0;
        in_valid = 1'b1;
        op = o;
        a = av;
        b = bv;
        cin = c;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Model: results follow request order; each op is plain integer math.
    function automatic exp_t model_op(input logic [1:0] o, input logic [7:0] av,
                                      input logic [7:0] bv, input logic c);
        exp_t e;
        int   r;
        int   ss;
        r  = 0;
        ss = 0;
        case (o)
            OP_ADD: begin
                r  = int'(av) + int'(bv) + int'(c);
                ss = int'($signed(av)) + int'($signed(bv)) + int'(c);
            end
            OP_SUB: begin
                r  = int'(av) + (255 - int'(bv)) + 1;
                ss = int'($signed(av)) - int'($signed(bv));
            end
            OP_ACC: begin
                r  = int'(macc) + int'(av) + int'(c);
                ss = int'($signed(macc)) + int'($signed(av)) + int'(c);
            end
            default: ;
        endcase
        e.s  = r[7:0];
        e.co = r[8];
        e.ov = (ss > 127) || (ss < -128);
        if (o == OP_ACC) begin
            macc = e.s;
            if (e.ov) maovf = 1'b1;
        end else if (o == OP_CLR) begin
            macc  = 8'h00;
            maovf = 1'b0;
        end
        e.ao = maovf;
        return e;
    endfunction

    // Compare process: every cycle a result is shown it must match the
    // oldest outstanding request.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                expq.delete();
                macc  = 8'h00;
                maovf = 1'b0;
            end else begin
                if (out_valid) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stale_result: out_valid=1 sum=%0h, expected no result pending", sum);
                    end else begin
                        chk("sum", 32'(sum), 32'(expq[0].s));
                        chk("cout", 32'(cout), 32'(expq[0].co));
                        chk("ovf", 32'(ovf), 32'(expq[0].ov));
                        chk("acc_ovf", 32'(acc_ovf), 32'(expq[0].ao));
                        if (out_ready) begin
                            if (nlog < 256) begin
                                lsum[nlog] = sum;
                                lco[nlog]  = cout;
                                lov[nlog]  = ovf;
                                lao[nlog]  = acc_ovf;
                            end
                            nlog++;
                            void'(expq.pop_front());
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    expq.push_back(model_op(op, a, b, cin));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        in_valid = 1'b0;
        op = 2'b00;
        a = 8'h00;
        b = 8'h00;
        cin = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();

        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_acc_ovf", 32'(acc_ovf), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        step();

        // Latency and signed overflow on ADD.
        send(OP_ADD, 8'h7F, 8'h01, 1'b0);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        step();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("add7f_sum", 32'(sum), 32'h80);
        chk("add7f_cout", 32'(cout), 32'd0);
        chk("add7f_ovf", 32'(ovf), 32'd1);
        step();

        // Subtraction, borrow and no-borrow, back to back.
        base = nlog;
        send(OP_SUB, 8'h05, 8'h07, 1'b0);
        chk("sub_throughput", 32'(in_ready), 32'd1);
        send(OP_SUB, 8'h07, 8'h05, 1'b1);
        repeat (3) step();
        chk("sub1_sum", 32'(lsum[base]), 32'hFE);
        chk("sub1_cout", 32'(lco[base]), 32'd0);
        chk("sub1_ovf", 32'(lov[base]), 32'd0);
        chk("sub2_sum", 32'(lsum[base+1]), 32'h02);
        chk("sub2_cout", 32'(lco[base+1]), 32'd1);

        // Clear then three accumulates with the one-cycle interlock.
        base = nlog;
        send(OP_CLR, 8'hAA, 8'h55, 1'b1);
        chk("clr_interlock", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send(OP_ACC, 8'h10, 8'h00, 1'b1);
            chk("acc_interlock", 32'(in_ready), 32'd0);
        end
        repeat (4) step();
        chk("clr_sum", 32'(lsum[base]), 32'h00);
        chk("acc1_sum", 32'(lsum[base+1]), 32'h11);
        chk("acc2_sum", 32'(lsum[base+2]), 32'h22);
        chk("acc3_sum", 32'(lsum[base+3]), 32'h33);

        // Backpressure: two held, third waits until release.
        base = nlog;
        out_ready = 1'b0;
        send(OP_ADD, 8'h01, 8'h02, 1'b0);
        send(OP_ADD, 8'h10, 8'h20, 1'b0);
        in_valid = 1'b1;
        op = OP_ADD;
        a = 8'h40;
        b = 8'h50;
        cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sum_hold", 32'(sum), 32'h03);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp_count", 32'(nlog - base), 32'd3);
        chk("bp_first", 32'(lsum[base]), 32'h03);
        chk("bp_second", 32'(lsum[base+1]), 32'h30);
        chk("bp_third", 32'(lsum[base+2]), 32'h90);
        chk("bp_third_ovf", 32'(lov[base+2]), 32'd1);

        // Sticky accumulator overflow.
        base = nlog;
        send(OP_CLR, 8'h00, 8'h00, 1'b0);
        send(OP_ACC, 8'h7F, 8'h00, 1'b0);
        send(OP_ACC, 8'h01, 8'h00, 1'b0);
        send(OP_ADD, 8'h01, 8'h01, 1'b0);
        send(OP_CLR, 8'h00, 8'h00, 1'b0);
        repeat (4) step();
        chk("acc7f_sum", 32'(lsum[base+1]), 32'h7F);
        chk("acc7f_aovf", 32'(lao[base+1]), 32'd0);
        chk("acc80_sum", 32'(lsum[base+2]), 32'h80);
        chk("acc80_ovf", 32'(lov[base+2]), 32'd1);
        chk("acc80_aovf", 32'(lao[base+2]), 32'd1);
        chk("add_keeps_aovf", 32'(lao[base+3]), 32'd1);
        chk("add_after_sum", 32'(lsum[base+3]), 32'h02);
        chk("clr_clears_aovf", 32'(lao[base+4]), 32'd0);

        // Mixed vectors under an irregular out_ready pattern.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = (i % 3) != 1;
                end
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    send(t_op[i], t_a[i], t_b[i], t_c[i]);
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) step();
        chk("mixed_drained", 32'(expq.size()), 32'd0);

        // Reset with two requests in flight.
        send(OP_CLR, 8'h00, 8'h00, 1'b0);
        send(OP_ACC, 8'h7F, 8'h00, 1'b0);
        send(OP_ACC, 8'h01, 8'h00, 1'b0);
        repeat (3) step();
        chk("aovf_before_rst", 32'(acc_ovf), 32'd1);
        out_ready = 1'b0;
        send(OP_ADD, 8'h11, 8'h22, 1'b0);
        send(OP_ADD, 8'h33, 8'h44, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_acc_ovf", 32'(acc_ovf), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        chk("postrst_out_valid", 32'(out_valid), 32'd0);
        step();
        out_ready = 1'b1;
        base = nlog;
        send(OP_ACC, 8'h00, 8'h00, 1'b0);
        repeat (3) step();
        chk("postrst_count", 32'(nlog - base), 32'd1);
        chk("postrst_acc_zero", 32'(lsum[base]), 32'h00);
        chk("postrst_aovf", 32'(lao[base]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
